// File: rtl/seq_chunk_adder_pkg.sv
// Shared state encoding and sizing helper for the sequential chunked adder.
package adder_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} adder_state_t;

   // Chunk counter width; kept at least 1 bit so NCHUNK=1 still elaborates.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder; slave is the adder side.
interface seq_chunk_adder_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/seq_chunk_adder_chunk.sv
// CHUNK-bit combinational ripple-carry slice; c_msb is the carry into the top bit.
module chunk_adder #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] s,
   output logic             cout,
   output logic             c_msb
);
   logic [CHUNK:0] w_c;

   assign w_c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s[i]       = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign cout  = w_c[CHUNK];
   assign c_msb = w_c[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential WIDTH-bit adder, CHUNK bits per cycle; result valid NCHUNK+1 cycles after accept,
// held in DONE until out_ready with no new operands taken. SEQ_ADDER_SUB_EN enables a-b via sub.
module seq_chunk_adder #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_chunk_adder_if.slave   bus
);
   import adder_pkg::*;

   localparam int             NCHUNK   = WIDTH / CHUNK;
   localparam int             CW       = cnt_width(NCHUNK);
   localparam logic [CW-1:0]  LAST_CNT = CW'(NCHUNK - 1);

   if (CHUNK < 1) begin : g_bad_chunk
      $error("seq_chunk_adder: CHUNK must be at least 1");
   end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
      $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
   end

   adder_state_t     r_state;
   adder_state_t     w_state_nxt;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;

   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_b_in;
   logic             w_c_in;
   logic [CHUNK-1:0] w_s;
   logic             w_cout;
   logic             w_cmsb;
   logic [WIDTH-1:0] w_sum_nxt;

   assign w_accept = bus.in_valid && (r_state == IDLE);
   assign w_last   = (r_cnt == LAST_CNT);

`ifdef SEQ_ADDER_SUB_EN
   // Subtraction as a + ~b + 1; cin has no meaning in this mode.
   assign w_b_in = bus.sub ? ~bus.b : bus.b;
   assign w_c_in = bus.sub ? 1'b1   : bus.cin;
`else
   logic w_unused_sub;
   assign w_unused_sub = bus.sub;
   assign w_b_in       = bus.b;
   assign w_c_in       = bus.cin;
`endif

   chunk_adder #(.CHUNK(CHUNK)) u_chunk (
      .a     (r_a[CHUNK-1:0]),
      .b     (r_b[CHUNK-1:0]),
      .cin   (r_carry),
      .s     (w_s),
      .cout  (w_cout),
      .c_msb (w_cmsb)
   );

   if (NCHUNK == 1) begin : g_one_chunk
      assign w_sum_nxt = w_s;
   end else begin : g_multi_chunk
      assign w_sum_nxt = {w_s, r_sum[WIDTH-1:CHUNK]};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (bus.in_valid)  w_state_nxt = BUSY;
         BUSY:    if (w_last)        w_state_nxt = DONE;
         DONE:    if (bus.out_ready) w_state_nxt = IDLE;
         default:                    w_state_nxt = IDLE;
      endcase
   end

   // Operand shift registers carry no reset: they are always loaded before use.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a <= bus.a;
         r_b <= w_b_in;
      end else if (r_state == BUSY) begin
         r_a <= r_a >> CHUNK;
         r_b <= r_b >> CHUNK;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_carry <= w_c_in;
      end else if (r_state == BUSY) begin
         r_cnt   <= r_cnt + 1'b1;
         r_carry <= w_cout;
         r_sum   <= w_sum_nxt;
         if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= w_cout ^ w_cmsb;
         end
      end
   end

   assign bus.in_ready  = (r_state == IDLE);
   assign bus.out_valid = (r_state == DONE);
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_ovf;
endmodule
